// File: rtl/hazard_scheduler.sv
// Hazard controller for the 5-stage RV32 core: stall/flush of F/D/E, E-stage operand forwarding,
// and sequencing of the shared multi-cycle multiply/divide unit with its single pending destination.
module hazard_scheduler #(
    parameter int MUL_LATENCY = 4,
    parameter int REG_AW      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic              MulD,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [1:0]        ResultSrcE,
    input  logic              PCSrcE,
    input  logic              MulStartE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              MulBusy,
    output logic              MulWbEn,
    output logic [REG_AW-1:0] MulWbRd,
    output logic              ErrOverlap
);

    localparam int            CW        = $clog2(MUL_LATENCY) + 1;
    localparam logic [CW-1:0] LAT_M1    = CW'(MUL_LATENCY - 1);
    localparam bit            ONE_CYCLE = (MUL_LATENCY == 1);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    state_e            state_q;
    logic [CW-1:0]     count_q;
    logic [REG_AW-1:0] pend_rd_q;
    logic [REG_AW-1:0] wb_rd_q;
    logic              busy_q;
    logic              wb_en_q;
    logic              err_q;

    logic              lw_stall;
    logic              mul_stall;
    logic              any_stall;

    // M-stage result is younger than W-stage, so it wins; x0 is hardwired and never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                           input logic              we_m,
                                           input logic [REG_AW-1:0] rd_m,
                                           input logic              we_w,
                                           input logic [REG_AW-1:0] rd_w);
        if (we_m && (rd_m != '0) && (rd_m == rs)) begin
            return 2'b10;
        end else if (we_w && (rd_w != '0) && (rd_w == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
    assign ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);

    assign lw_stall  = (ResultSrcE == 2'b01) && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign mul_stall = busy_q && (MulD || ((pend_rd_q != '0) &&
                                           ((pend_rd_q == Rs1D) || (pend_rd_q == Rs2D))));
    assign any_stall = lw_stall || mul_stall;

    // A taken branch squashes whatever D holds, so holding F/D would only delay the redirect.
    assign StallF = any_stall && !PCSrcE;
    assign StallD = any_stall && !PCSrcE;
    assign FlushD = PCSrcE;
    assign FlushE = any_stall || PCSrcE;

    // Completion outputs are registered one cycle ahead so MulWbEn/MulWbRd come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            pend_rd_q <= '0;
            wb_rd_q   <= '0;
            busy_q    <= 1'b0;
            wb_en_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (MulStartE) begin
                        state_q   <= S_BUSY;
                        count_q   <= LAT_M1;
                        pend_rd_q <= RdE;
                        busy_q    <= 1'b1;
                        wb_en_q   <= ONE_CYCLE;
                        wb_rd_q   <= ONE_CYCLE ? RdE : '0;
                    end
                end
                S_BUSY: begin
                    if (MulStartE) begin
                        err_q <= 1'b1;
                    end
                    if (count_q != '0) begin
                        count_q <= count_q - 1'b1;
                        wb_en_q <= (count_q == CW'(1));
                        wb_rd_q <= (count_q == CW'(1)) ? pend_rd_q : '0;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        wb_en_q <= 1'b0;
                        wb_rd_q <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    wb_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign MulBusy    = busy_q;
    assign MulWbEn    = wb_en_q;
    assign MulWbRd    = wb_rd_q;
    assign ErrOverlap = err_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Self-checking bench for hazard_scheduler: directed scenarios plus randomized stimulus checked
// against a cycle-indexed reference model of the multi-cycle unit.
module tb_hazard_scheduler;

    localparam int L  = 4;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          MulD, PCSrcE, MulStartE, RegWriteM, RegWriteW;
    logic [1:0]    ResultSrcE;
    logic          StallF, StallD, FlushD, FlushE, MulBusy, MulWbEn, ErrOverlap;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [AW-1:0] MulWbRd;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hazard_scheduler #(.MUL_LATENCY(L), .REG_AW(AW)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .MulD(MulD),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ResultSrcE(ResultSrcE),
        .PCSrcE(PCSrcE), .MulStartE(MulStartE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MulBusy(MulBusy), .MulWbEn(MulWbEn), .MulWbRd(MulWbRd), .ErrOverlap(ErrOverlap)
    );

    // Reference model: an accepted op occupies cycles [accept+1, accept+L] and writes back in the last.
    int            cyc       = 0;
    int            m_wb_cyc  = 0;
    bit            m_active  = 1'b0;
    bit            m_err     = 1'b0;
    logic [AW-1:0] m_pend    = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
            m_err    <= 1'b0;
            m_pend   <= '0;
        end else if (m_active) begin
            if (MulStartE) m_err <= 1'b1;
            if (cyc == m_wb_cyc) m_active <= 1'b0;
        end else if (MulStartE) begin
            m_active <= 1'b1;
            m_wb_cyc <= cyc + L;
            m_pend   <= RdE;
        end
        cyc <= cyc + 1;
    end

    function automatic logic [1:0] ref_fwd(input logic [AW-1:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {MulD, PCSrcE, MulStartE, RegWriteM, RegWriteW} = '0;
        ResultSrcE = 2'b00;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        n_tests++; if ({StallF, StallD, FlushD, FlushE} !== 4'b0) begin n_fail++;
            $display("FAIL reset_ctl: stall/flush=%b want 0000", {StallF, StallD, FlushD, FlushE}); end
        n_tests++; if ({ForwardAE, ForwardBE} !== 4'b0) begin n_fail++;
            $display("FAIL reset_fwd: fwd=%b want 0000", {ForwardAE, ForwardBE}); end
        n_tests++; if ({MulBusy, MulWbEn, ErrOverlap} !== 3'b0 || MulWbRd !== '0) begin n_fail++;
            $display("FAIL reset_mul: busy/wb/err=%b rd=%0d want 000 rd=0",
                     {MulBusy, MulWbEn, ErrOverlap}, MulWbRd); end
    endtask

    task automatic test_forwarding();
        clear_inputs();
        RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 5;
        settle();
        n_tests++; if (ForwardAE !== 2'b10 || ForwardBE !== 2'b10) begin n_fail++;
            $display("FAIL fwd_m_prio: A=%b B=%b want 10 10", ForwardAE, ForwardBE); end
        RdM = 0;
        settle();
        n_tests++; if (ForwardAE !== 2'b01 || ForwardBE !== 2'b01) begin n_fail++;
            $display("FAIL fwd_w: A=%b B=%b want 01 01", ForwardAE, ForwardBE); end
        RdM = 5; RegWriteM = 0; RegWriteW = 0; Rs2E = 6;
        settle();
        n_tests++; if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00) begin n_fail++;
            $display("FAIL fwd_no_we: A=%b B=%b want 00 00", ForwardAE, ForwardBE); end
        RdM = 0; RdW = 0; RegWriteM = 1; RegWriteW = 1; Rs1E = 0; Rs2E = 0;
        settle();
        n_tests++; if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00) begin n_fail++;
            $display("FAIL fwd_x0: A=%b B=%b want 00 00", ForwardAE, ForwardBE); end
        clear_inputs();
    endtask

    task automatic test_load_stall();
        clear_inputs();
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        settle();
        n_tests++; if ({StallF, StallD, FlushD, FlushE} !== 4'b1101) begin n_fail++;
            $display("FAIL lw_stall: SF/SD/FD/FE=%b want 1101", {StallF, StallD, FlushD, FlushE}); end
        RdE = 0; Rs2D = 0;
        settle();
        n_tests++; if ({StallF, StallD, FlushD, FlushE} !== 4'b0000) begin n_fail++;
            $display("FAIL lw_x0: SF/SD/FD/FE=%b want 0000", {StallF, StallD, FlushD, FlushE}); end
        ResultSrcE = 2'b10; RdE = 7; Rs1D = 7;
        settle();
        n_tests++; if ({StallF, StallD, FlushE} !== 3'b000) begin n_fail++;
            $display("FAIL lw_not_load: SF/SD/FE=%b want 000", {StallF, StallD, FlushE}); end
        clear_inputs();
    endtask

    task automatic test_branch_override();
        clear_inputs();
        ResultSrcE = 2'b01; RdE = 7; Rs1D = 7; PCSrcE = 1;
        settle();
        n_tests++; if ({StallF, StallD, FlushD, FlushE} !== 4'b0011) begin n_fail++;
            $display("FAIL br_override: SF/SD/FD/FE=%b want 0011", {StallF, StallD, FlushD, FlushE}); end
        clear_inputs();
        do_reset();
        MulStartE = 1; PCSrcE = 1; RdE = 4;
        cycle();
        clear_inputs();
        settle();
        n_tests++; if (MulBusy !== 1'b1) begin n_fail++;
            $display("FAIL start_with_branch: MulBusy=%b want 1", MulBusy); end
        repeat (L + 1) cycle();
    endtask

    task automatic test_mul_sequence();
        do_reset();
        MulStartE = 1; RdE = 9;
        cycle();
        clear_inputs();
        Rs1D = 9;
        for (int k = 1; k <= L + 1; k++) begin
            settle();
            n_tests++; if (MulBusy !== (k <= L) || MulWbEn !== (k == L)) begin n_fail++;
                $display("FAIL mul_seq_c%0d: busy=%b wb=%b want %b %b", k, MulBusy, MulWbEn, k <= L, k == L); end
            n_tests++; if (StallD !== (k <= L) || StallF !== (k <= L) || FlushE !== (k <= L)) begin n_fail++;
                $display("FAIL mul_dep_c%0d: SD=%b SF=%b FE=%b want %b", k, StallD, StallF, FlushE, k <= L); end
            if (k == L) begin
                n_tests++; if (MulWbRd !== 5'd9) begin n_fail++;
                    $display("FAIL mul_wbrd: MulWbRd=%0d want 9", MulWbRd); end
            end
            cycle();
        end
        clear_inputs();
    endtask

    task automatic test_overlap();
        do_reset();
        MulStartE = 1; RdE = 3;
        cycle();
        RdE = 12; MulD = 1;
        settle();
        n_tests++; if (StallD !== 1'b1 || ErrOverlap !== 1'b0) begin n_fail++;
            $display("FAIL ovl_muld: SD=%b err=%b want 1 0", StallD, ErrOverlap); end
        cycle();
        clear_inputs();
        for (int k = 2; k <= L + 2; k++) begin
            settle();
            n_tests++; if (ErrOverlap !== 1'b1 || MulWbEn !== (k == L)) begin n_fail++;
                $display("FAIL ovl_c%0d: err=%b wb=%b want 1 %b", k, ErrOverlap, MulWbEn, k == L); end
            if (k == L) begin
                n_tests++; if (MulWbRd !== 5'd3) begin n_fail++;
                    $display("FAIL ovl_wbrd: MulWbRd=%0d want 3", MulWbRd); end
            end
            cycle();
        end
        MulD = 1;
        settle();
        n_tests++; if (StallD !== 1'b0 || MulBusy !== 1'b0) begin n_fail++;
            $display("FAIL ovl_idle_muld: SD=%b busy=%b want 0 0", StallD, MulBusy); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        MulStartE = 1; RdE = 6;
        cycle();
        clear_inputs();
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        for (int k = 0; k < L + 1; k++) begin
            settle();
            n_tests++; if (MulBusy !== 1'b0 || MulWbEn !== 1'b0) begin n_fail++;
                $display("FAIL rst_mid_c%0d: busy=%b wb=%b want 0 0", k, MulBusy, MulWbEn); end
            cycle();
        end
    endtask

    task automatic test_random();
        logic       lw, ms, stall;
        logic [1:0] efa, efb;
        bit         ewb;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(39) == 0);
            Rs1D       = AW'($urandom_range(3));
            Rs2D       = AW'($urandom_range(3));
            Rs1E       = AW'($urandom_range(3));
            Rs2E       = AW'($urandom_range(3));
            RdE        = AW'($urandom_range(3));
            RdM        = AW'($urandom_range(3));
            RdW        = AW'($urandom_range(3));
            RegWriteM  = 1'($urandom_range(1));
            RegWriteW  = 1'($urandom_range(1));
            ResultSrcE = 2'($urandom_range(3));
            MulD       = ($urandom_range(3) == 0);
            PCSrcE     = ($urandom_range(7) == 0);
            MulStartE  = ($urandom_range(5) == 0);
            settle();
            lw    = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
            ms    = m_active && (MulD || (m_pend != 0 && (m_pend == Rs1D || m_pend == Rs2D)));
            stall = (lw || ms) && !PCSrcE;
            efa   = ref_fwd(Rs1E);
            efb   = ref_fwd(Rs2E);
            ewb   = m_active && (cyc == m_wb_cyc);
            n_tests++; if (ForwardAE !== efa || ForwardBE !== efb) begin n_fail++;
                $display("FAIL rnd_fwd@%0d: A=%b B=%b want %b %b", i, ForwardAE, ForwardBE, efa, efb); end
            n_tests++; if (StallF !== stall || StallD !== stall) begin n_fail++;
                $display("FAIL rnd_stall@%0d: SF=%b SD=%b want %b", i, StallF, StallD, stall); end
            n_tests++; if (FlushD !== PCSrcE || FlushE !== (lw || ms || PCSrcE)) begin n_fail++;
                $display("FAIL rnd_flush@%0d: FD=%b FE=%b want %b %b", i, FlushD, FlushE, PCSrcE, lw || ms || PCSrcE); end
            n_tests++; if (MulBusy !== m_active || MulWbEn !== ewb || ErrOverlap !== m_err) begin n_fail++;
                $display("FAIL rnd_mul@%0d: busy=%b wb=%b err=%b want %b %b %b",
                         i, MulBusy, MulWbEn, ErrOverlap, m_active, ewb, m_err); end
            if (ewb) begin
                n_tests++; if (MulWbRd !== m_pend) begin n_fail++;
                    $display("FAIL rnd_wbrd@%0d: MulWbRd=%0d want %0d", i, MulWbRd, m_pend); end
            end
            cycle();
        end
        rst = 0;
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_stall();
        test_branch_override();
        test_mul_sequence();
        test_overlap();
        test_reset_mid_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
